// File: rtl/rob_retire_ctrl.sv
// Purpose : in-order ROB retirement sequencer with mispredict tail restore, recovery freeze and sticky halt.
// Latency : num_retiring / tail_restore_* are combinational (0 cycles); halted / recovering update at the next edge.
// Backpress: retire_stall=1 forces num_retiring=0 and suppresses restore/halt/recover transitions that cycle.
// Optional : define RETIRE_PERF_EN to build the retired_total / stall_cycles counters (tied to 0 otherwise).

`ifndef N
`define N 2
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif

module rob_retire_ctrl #(
  parameter int N           = `N,
  parameter int ROB_SZ      = `ROB_SZ,
  parameter int RECOVER_CYC = 2,
  localparam int NUM_SCALAR_BITS = $clog2(N + 1),
  localparam int ROB_SZ_BITS     = $clog2(ROB_SZ)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_SCALAR_BITS-1:0]          rob_outputs_valid,
  input  logic [N-1:0]                        head_complete,
  input  logic [N-1:0]                        head_mispredict,
  input  logic [N-1:0]                        head_halt,
  input  logic [N-1:0][ROB_SZ_BITS-1:0]       head_tail_ckpt,
  input  logic                                retire_stall,
  output logic [NUM_SCALAR_BITS-1:0]          num_retiring,
  output logic                                tail_restore_valid,
  output logic [ROB_SZ_BITS-1:0]              tail_restore,
  output logic                                halted,
  output logic                                recovering,
  output logic [31:0]                         retired_total,
  output logic [31:0]                         stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_RECOVER = 2'd1,
    S_HALTED  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;

  logic [NUM_SCALAR_BITS-1:0]  scan_cnt;
  logic                        scan_stop;
  logic                        hit_mis;
  logic                        hit_halt;
  logic [ROB_SZ_BITS-1:0]      hit_ckpt;

  logic [NUM_SCALAR_BITS-1:0]  num_d;
  logic                        trv_d;
  logic [ROB_SZ_BITS-1:0]      tr_d;

  // Oldest-first scan: count contiguous complete slots, stop after the first mispredict/halt.
  always_comb begin
    scan_cnt  = '0;
    scan_stop = 1'b0;
    hit_mis   = 1'b0;
    hit_halt  = 1'b0;
    hit_ckpt  = '0;
    for (int i = 0; i < N; i++) begin
      if (!scan_stop) begin
        if ((i < int'(rob_outputs_valid)) && head_complete[i]) begin
          scan_cnt = scan_cnt + NUM_SCALAR_BITS'(1);
          if (head_mispredict[i] || head_halt[i]) begin
            scan_stop = 1'b1;
            hit_mis   = head_mispredict[i];
            hit_halt  = head_halt[i];
            hit_ckpt  = head_tail_ckpt[i];
          end
        end else begin
          scan_stop = 1'b1;
        end
      end
    end
  end

  // Next-state and combinational retire outputs; HALTED takes priority over RECOVER.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = '0;
    trv_d   = 1'b0;
    tr_d    = '0;
    case (state_q)
      S_RUN: begin
        if (!retire_stall) begin
          num_d = scan_cnt;
          if (hit_mis) begin
            trv_d   = 1'b1;
            tr_d    = hit_ckpt;
            state_d = S_RECOVER;
            cnt_d   = 4'(RECOVER_CYC);
          end
          if (hit_halt) begin
            state_d = S_HALTED;
            cnt_d   = '0;
          end
        end
      end
      S_RECOVER: begin
        // Leave on the cycle the counter reaches zero; a zero count is treated as already expired.
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HALTED: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are held quiet while reset is asserted.
  assign num_retiring       = reset ? '0   : num_d;
  assign tail_restore_valid = reset ? 1'b0 : trv_d;
  assign tail_restore       = reset ? '0   : tr_d;

  // State and recovery counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted     = (state_q == S_HALTED);
  assign recovering = (state_q == S_RECOVER);

`ifdef RETIRE_PERF_EN
  logic [31:0] retired_total_q, retired_total_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        stall_hit;

  // Perf counters: retired entries (wrapping) and RUN cycles blocked only by downstream stall.
  always_comb begin
    stall_hit       = (state_q == S_RUN) && retire_stall &&
                      (rob_outputs_valid != '0) && head_complete[0];
    retired_total_d = retired_total_q + 32'(num_retiring);
    stall_cycles_d  = stall_cycles_q + (stall_hit ? 32'd1 : 32'd0);
  end

  // Perf counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_total_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      retired_total_q <= retired_total_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign retired_total = retired_total_q;
  assign stall_cycles  = stall_cycles_q;
`else
  assign retired_total = 32'd0;
  assign stall_cycles  = 32'd0;
`endif

endmodule
